// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store controller that sits between the execute
// stage and a word-addressed data memory. The memory has a combinational read
// and a synchronous write. Sub-word stores are done as read-modify-write of
// the containing word. Misaligned, illegal-size and out-of-range requests get
// an error response and never write memory.
// Optional feature: define LSU_PERF_CNT_EN to add load/store/error counters.

package params_pkg;
  localparam int MEM_SIZE   = 64;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
endpackage

module lsu_ctrl #(
  parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_loads_o,
  output logic [31:0]           perf_stores_o,
  output logic [31:0]           perf_errs_o
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Widened copy of MEM_SIZE so the range check also works when MEM_SIZE == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] MEM_SIZE_W = (ADDR_WIDTH+1)'(MEM_SIZE);

  generate
    if (DATA_WIDTH != 32) begin : g_badWidth
      $error("lsu_ctrl: DATA_WIDTH must be 32");
    end
  endgenerate

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_byteOff;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_reqErr;
  logic [ADDR_WIDTH:0]   w_wordIdx;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_byteShift;
  logic [DATA_WIDTH-1:0] w_halfShift;
  logic [DATA_WIDTH-1:0] w_loadData;

  assign w_accept   = req_valid_i && (r_state == IDLE);
  assign w_wordIdx  = {1'b0, req_addr_i[ADDR_WIDTH+1:2]};
  assign mem_addr_o = r_memAddr;

  // Classify the incoming request as bad (illegal size, misaligned or past the end of memory).
  always_comb begin
    w_reqErr = 1'b0;
    case (req_size_i)
      2'b01:   w_reqErr = req_addr_i[0];
      2'b10:   w_reqErr = |req_addr_i[1:0];
      2'b11:   w_reqErr = 1'b1;
      default: w_reqErr = 1'b0;
    endcase
    if (w_wordIdx >= MEM_SIZE_W) begin
      w_reqErr = 1'b1;
    end
  end

  // State register; a reset in any state abandons the access.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode; write and response strobes are masked while reset is held.
  always_comb begin
    w_nextState   = r_state;
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    resp_err_o    = 1'b0;
    resp_rdata_o  = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = '0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_reqErr) begin
            w_nextState = RESP;
          end else if (req_we_i && (req_size_i == 2'b10)) begin
            w_nextState = WR;
          end else begin
            w_nextState = RD;
          end
        end
      end
      RD: begin
        w_nextState = r_we ? WR : RESP;
      end
      WR: begin
        mem_wr_en_o   = rst_i;
        mem_wr_data_o = r_data;
        w_nextState   = RESP;
      end
      RESP: begin
        resp_valid_o = rst_i;
        resp_err_o   = rst_i && r_err;
        resp_rdata_o = (rst_i && !r_err && !r_we) ? w_loadData : '0;
        w_nextState  = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Replace the addressed lane of the word just read with the store data.
  always_comb begin
    w_merged = mem_rd_data_i;
    case (r_size)
      2'b00:   w_merged[{r_byteOff, 3'b000} +: 8]      = r_wdata[7:0];
      2'b01:   w_merged[{r_byteOff[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  // Pull the addressed byte or half out of the read word and extend it.
  always_comb begin
    w_byteShift = r_data >> {r_byteOff, 3'b000};
    w_halfShift = r_data >> {r_byteOff[1], 4'b0000};
    case (r_size)
      2'b00:   w_loadData = {{24{r_signed & w_byteShift[7]}}, w_byteShift[7:0]};
      2'b01:   w_loadData = {{16{r_signed & w_halfShift[15]}}, w_halfShift[15:0]};
      default: w_loadData = r_data;
    endcase
  end

  // Latch the request on acceptance; r_data holds the write word for word stores, else the RD result.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_byteOff <= 2'b00;
      r_wdata   <= '0;
      r_memAddr <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_we      <= req_we_i;
      r_size    <= req_size_i;
      r_signed  <= req_signed_i;
      r_byteOff <= req_addr_i[1:0];
      r_wdata   <= req_wdata_i;
      r_memAddr <= req_addr_i[ADDR_WIDTH+1:2];
      r_data    <= req_wdata_i;
      r_err     <= w_reqErr;
    end else if (r_state == RD) begin
      r_data    <= r_we ? w_merged : mem_rd_data_i;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] r_perfLoads;
  logic [31:0] r_perfStores;
  logic [31:0] r_perfErrs;

  // Count each finished access by outcome during its response cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_perfLoads  <= '0;
      r_perfStores <= '0;
      r_perfErrs   <= '0;
    end else if (r_state == RESP) begin
      if (r_err) begin
        r_perfErrs <= r_perfErrs + 32'd1;
      end else if (r_we) begin
        r_perfStores <= r_perfStores + 32'd1;
      end else begin
        r_perfLoads <= r_perfLoads + 32'd1;
      end
    end
  end

  assign perf_loads_o  = r_perfLoads;
  assign perf_stores_o = r_perfStores;
  assign perf_errs_o   = r_perfErrs;
`endif

endmodule
